// File: rtl/nv_obs_misr_feeder.sv
// ---------------------------------------------------------------------------
// nv_obs_misr_feeder
//
// Compresses a wide bus of observation nets into a multiple-input signature
// register (MISR) over a window of WIN valid beats. The finished signature is
// then shifted out MSB-first on one serial net that ends in a sink cell, so
// the observed logic stays live through synthesis.
//
// Ports:
//   nvdla_core_clk  in   core clock, all state on rising edge
//   nvdla_core_rst  in   synchronous active-high reset
//   sig_start       in   one-cycle request to begin a signature (IDLE only)
//   obs_vld         in   obs_data valid this cycle
//   obs_data        in   [DW-1:0] observation word
//   busy            out  high while accumulating or shifting
//   sig_out         out  serial signature bit (0 when sig_out_vld is low)
//   sig_out_vld     out  sig_out carries a signature bit this cycle
//   sig_done        out  one-cycle pulse after the last serial bit
//
// Build option:
//   OBS_MISR_PARITY_EN  append one even-parity bit of the signature after
//                       bit 0; the shift phase lasts DW+1 cycles.
// ---------------------------------------------------------------------------
module nv_obs_misr_feeder #(
  parameter int            DW   = 32,
  parameter int            WIN  = 256,
  parameter logic [DW-1:0] POLY = 32'h04C11DB7,
  parameter logic [DW-1:0] SEED = '0
) (
  input  logic          nvdla_core_clk,
  input  logic          nvdla_core_rst,
  input  logic          sig_start,
  input  logic          obs_vld,
  input  logic [DW-1:0] obs_data,
  output logic          busy,
  output logic          sig_out,
  output logic          sig_out_vld,
  output logic          sig_done
);

  // cnt must be able to hold WIN itself, so it never wraps.
  localparam int CW = $clog2(WIN) + 1;
  localparam int IW = $clog2(DW);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    SHIFT
  } state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   misr_q,  misr_d;
  logic [CW-1:0]   cnt_q,   cnt_d;
  logic [IW-1:0]   idx_q,   idx_d;
  logic            done_q,  done_d;
  logic [DW-1:0]   misr_step;
`ifdef OBS_MISR_PARITY_EN
  logic            par_q,   par_d;
`endif

  // Shift left, fold the outgoing MSB back through the polynomial, then mix
  // in the new observation word.
  assign misr_step = {misr_q[DW-2:0], 1'b0}
                   ^ (misr_q[DW-1] ? POLY : '0)
                   ^ obs_data;

  assign busy     = (state_q != IDLE);
  assign sig_done = done_q;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_d     = state_q;
    misr_d      = misr_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    done_d      = 1'b0;
    sig_out     = 1'b0;
    sig_out_vld = 1'b0;
`ifdef OBS_MISR_PARITY_EN
    par_d       = par_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (sig_start) begin
          misr_d  = SEED;
          cnt_d   = '0;
          state_d = ACCUM;
        end
      end

      ACCUM: begin
        if (obs_vld) begin
          misr_d = misr_step;
          cnt_d  = cnt_q + CW'(1);
          if (cnt_q == CW'(WIN - 1)) begin
            state_d = SHIFT;
            idx_d   = IW'(DW - 1);
          end
        end
      end

      SHIFT: begin
        sig_out_vld = 1'b1;
`ifdef OBS_MISR_PARITY_EN
        if (par_q) begin
          sig_out = ^misr_q;
          par_d   = 1'b0;
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          sig_out = misr_q[idx_q];
          if (idx_q != '0) idx_d = idx_q - IW'(1);
          else             par_d = 1'b1;
        end
`else
        sig_out = misr_q[idx_q];
        if (idx_q != '0) begin
          idx_d = idx_q - IW'(1);
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
`endif
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: the reset is synchronous, so it is tested inside the clocked block
  // and is absent from the sensitivity list.
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples pre-edge values regardless of statement order.
      state_q <= IDLE;
      misr_q  <= SEED;
      cnt_q   <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
`ifdef OBS_MISR_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      misr_q  <= misr_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
`ifdef OBS_MISR_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule
